// File: rtl/cpu_types_pkg.sv
// Shared CPU types: bus word, RAM handshake state and the memory arbiter FSM encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        IGRANT,
        DGRANT
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises icache fills and dcache accesses onto the single RAM port.
// Dcache has priority; a saturating counter forces an icache grant after STARVE_LIMIT dcache wins.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    arb_state_t      state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic            dreq;
    logic            access;

    assign dreq   = dREN | dWEN;
    assign access = (ramstate == ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;

        unique case (state_q)
            IDLE: begin
                if (dreq && !(iREN && count_q == CntMax)) begin
                    state_d = DGRANT;
                    if (!iREN) begin
                        count_d = '0;
                    end else if (count_q != CntMax) begin
                        count_d = count_q + 1'b1;
                    end
                end else if (iREN) begin
                    state_d = IGRANT;
                    count_d = '0;
                end
            end
            IGRANT: begin
                // A dropped request aborts the grant with no completion.
                if (iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    iload   = ramload;
                    if (access) begin
                        iwait   = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DGRANT: begin
                if (dreq) begin
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    dload    = ramload;
                    if (access) begin
                        dwait   = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench drives ramstate/ramload cycle by cycle.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_checks = 0;
    int n_fails  = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks follow 1ns later.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        ramstate = FREE; ramload = '0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #7;
        nRST = 1'b1;
        cyc();
    endtask

    initial begin
        int dcomp;
        int icomp;
        nRST = 1'b1;
        iaddr = '0; daddr = '0; dstore = '0;
        idle_inputs();

        // Reset values with a request already pending.
        #2;
        nRST = 1'b0;
        iREN = 1'b1; iaddr = 32'h44; ramload = 32'h1111_2222; ramstate = ACCESS;
        settle();
        check_eq("rst_iwait", iwait, 1);
        check_eq("rst_dwait", dwait, 1);
        check_eq("rst_ramREN", ramREN, 0);
        check_eq("rst_ramWEN", ramWEN, 0);
        check_eq("rst_ramaddr", ramaddr, 0);
        check_eq("rst_iload", iload, 0);
        idle_inputs();
        #5;
        nRST = 1'b1;
        cyc();

        // Single icache read, ACCESS two cycles after the strobe.
        iREN = 1'b1; iaddr = 32'h40;
        settle();
        check_eq("ird_idle_ramREN", ramREN, 0);
        cyc();
        ramstate = BUSY; settle();
        check_eq("ird_c1_ramREN", ramREN, 1);
        check_eq("ird_c1_ramaddr", ramaddr, 32'h40);
        check_eq("ird_c1_iwait", iwait, 1);
        cyc();
        settle();
        check_eq("ird_c2_iwait", iwait, 1);
        cyc();
        ramstate = ACCESS; ramload = 32'hDEAD_BEEF; settle();
        check_eq("ird_c3_iwait", iwait, 0);
        check_eq("ird_c3_iload", iload, 32'hDEAD_BEEF);
        cyc();
        settle();
        check_eq("ird_bubble_ramREN", ramREN, 0);
        check_eq("ird_bubble_iwait", iwait, 1);
        check_eq("ird_bubble_iload", iload, 0);
        idle_inputs();
        cyc();

        // Simultaneous icache read and dcache write: dcache first, then bubble, then icache.
        iREN = 1'b1; iaddr = 32'h60; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
        cyc();
        ramstate = ACCESS; settle();
        check_eq("pri_ramWEN", ramWEN, 1);
        check_eq("pri_ramREN", ramREN, 0);
        check_eq("pri_ramaddr", ramaddr, 32'h80);
        check_eq("pri_ramstore", ramstore, 32'h1234);
        check_eq("pri_dwait", dwait, 0);
        check_eq("pri_iwait", iwait, 1);
        cyc();
        dWEN = 1'b0; ramstate = FREE; settle();
        check_eq("pri_bubble_iwait", iwait, 1);
        check_eq("pri_bubble_ramWEN", ramWEN, 0);
        cyc();
        ramstate = ACCESS; ramload = 32'h0000_0055; settle();
        check_eq("pri_i_ramaddr", ramaddr, 32'h60);
        check_eq("pri_i_iwait", iwait, 0);
        check_eq("pri_i_iload", iload, 32'h55);
        cyc();
        idle_inputs();
        cyc();

        // Starvation guard: four dcache completions, then the icache grant.
        iREN = 1'b1; dREN = 1'b1; daddr = 32'h90; ramstate = ACCESS;
        dcomp = 0; icomp = 0;
        for (int i = 0; i < 30 && icomp == 0; i++) begin
            cyc();
            settle();
            if (!dwait) dcomp++;
            if (!iwait) begin
                icomp++;
                check_eq("stv_dcomp_before_i", dcomp, 4);
                check_eq("stv_count_cleared", dut.count_q, 0);
                check_eq("stv_i_ramaddr", ramaddr, 32'h40 + 32'h20);
            end
        end
        check_eq("stv_i_granted", icomp, 1);
        // With dREN still held the dcache wins again after the bubble.
        cyc();
        settle();
        check_eq("stv_bubble_dwait", dwait, 1);
        cyc();
        settle();
        check_eq("stv_d_again", dwait, 0);
        idle_inputs();
        do_reset();

        // Abort: dREN drops before ACCESS; pending iREN follows.
        iREN = 1'b1; iaddr = 32'h70; dREN = 1'b1; daddr = 32'h100; ramstate = BUSY;
        cyc();
        settle();
        check_eq("abt_ramREN_on", ramREN, 1);
        check_eq("abt_ramaddr", ramaddr, 32'h100);
        cyc();
        dREN = 1'b0; ramstate = ACCESS; settle();
        check_eq("abt_ramREN_off", ramREN, 0);
        check_eq("abt_dwait", dwait, 1);
        check_eq("abt_iwait", iwait, 1);
        cyc();
        ramstate = BUSY; settle();
        check_eq("abt_idle_ramREN", ramREN, 0);
        cyc();
        settle();
        check_eq("abt_i_ramREN", ramREN, 1);
        check_eq("abt_i_ramaddr", ramaddr, 32'h70);
        idle_inputs();
        cyc();
        cyc();

        // ERROR retried until ACCESS.
        dREN = 1'b1; daddr = 32'h200;
        cyc();
        for (int i = 0; i < 5; i++) begin
            ramstate = ERROR; settle();
            check_eq($sformatf("err_dwait_%0d", i), dwait, 1);
            check_eq($sformatf("err_ramREN_%0d", i), ramREN, 1);
            cyc();
        end
        ramstate = ACCESS; ramload = 32'hCAFE; settle();
        check_eq("err_done_dwait", dwait, 0);
        check_eq("err_done_dload", dload, 32'hCAFE);
        cyc();
        idle_inputs();
        cyc();

        // Reset pulse while icache is granted.
        iREN = 1'b1; iaddr = 32'h300; ramstate = BUSY;
        cyc();
        settle();
        check_eq("rmg_ramREN", ramREN, 1);
        nRST = 1'b0;
        settle();
        check_eq("rmg_rst_ramREN", ramREN, 0);
        check_eq("rmg_rst_ramaddr", ramaddr, 0);
        check_eq("rmg_rst_iwait", iwait, 1);
        #2;
        nRST = 1'b1;
        settle();
        check_eq("rmg_idle_ramREN", ramREN, 0);
        cyc();
        settle();
        check_eq("rmg_restart_ramREN", ramREN, 1);
        check_eq("rmg_restart_ramaddr", ramaddr, 32'h300);
        idle_inputs();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter between the instruction cache and the data cache, ahead of the single-ported RAM. It serialises icache fills and dcache reads/writes onto one RAM port and returns wait/load to the requesting cache. The data cache has priority, with a starvation guard that guarantees instruction fetch forward progress. It sits between the caches block and the RAM model/bus.

## Interface
- STARVE_LIMIT, 4: consecutive dcache grants allowed while iREN is pending before icache is forced a grant (≥1).
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  low for exactly the completing cycle of an icache read; high otherwise.
- iload  out  32  read data to icache; valid when iwait low.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request; wins over dREN if both high.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  low for exactly the completing cycle of a dcache access; high otherwise.
- dload  out  32  read data to dcache; valid when dwait low.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

## Operation
- FSM states: IDLE, IGRANT, DGRANT. Reset state is IDLE, with the starvation counter at 0.
- Arbitration happens in IDLE only. Let dreq = dREN|dWEN.
  - dreq, and not (iREN and count==STARVE_LIMIT): go to DGRANT.
  - Otherwise, if iREN: go to IGRANT.
  - Otherwise: stay in IDLE.
- Starvation counter, updated on the IDLE→grant edge:
  - DGRANT while iREN high: increment, saturating at STARVE_LIMIT.
  - DGRANT while iREN low: clear.
  - Any IGRANT: clear.
- IGRANT outputs (combinational from state, gated by iREN):
  - ramREN = iREN, ramaddr = iaddr, ramWEN = 0.
  - iload = ramload.
- DGRANT outputs (gated by dreq):
  - ramWEN = dWEN, ramREN = dREN & ~dWEN, ramaddr = daddr, ramstore = dstore.
  - dload = ramload.
- Completion: the owner's request is high and ramstate==ACCESS. The owner's wait goes low that cycle and the FSM returns to IDLE at the next edge.
- Non-owner wait is always high. In IDLE both waits are high and all RAM outputs are 0.
- ramstate BUSY, FREE or ERROR while granted: hold state and keep driving. ERROR is retried indefinitely and never completes.
- Abort: if the owner's request drops while granted, RAM strobes drop the same cycle and the FSM returns to IDLE at the next edge. No completion is reported.
- The owner may change its address mid-grant. The RAM sees the new address immediately, and the arbiter does not latch addresses.

## Timing
- Reset values: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
- The grant is registered. A request arriving in IDLE at cycle 0 drives RAM in cycle 1. The earliest completion (ACCESS in cycle 1) makes wait low in cycle 1.
- There is one mandatory IDLE bubble between consecutive transactions, including back-to-back requests from the same cache.
- iload and dload are combinational from ramload when granted, and 0 otherwise.
- Reset asserted mid-transaction: the FSM goes to IDLE, the counter clears, and outputs take reset values immediately (asynchronous).
- Simultaneous iREN and dWEN with count<STARVE_LIMIT: dcache is granted. With count==STARVE_LIMIT: icache is granted.

## Structure
- ramstate_t, word_t and the arbiter state enum (IDLE/IGRANT/DGRANT) belong in cpu_types_pkg.
- The starvation counter width is $clog2(STARVE_LIMIT+1), local to the module.
- A single module. No sub-module is warranted.

## Test plan
- **Reset values:** nRST low with iREN=1 → iwait=1, dwait=1, ramREN=0, ramWEN=0, all data outputs 0.
- **Single icache read:** iREN=1, iaddr=0x40; RAM returns ACCESS two cycles after ramREN with ramload=0xDEADBEEF → ramaddr=0x40 from cycle 1; iwait low for one cycle with iload=0xDEADBEEF; back to IDLE next edge.
- **dcache priority:** iREN, dWEN, daddr=0x80 and dstore=0x1234 asserted together → ramWEN=1, ramaddr=0x80, ramstore=0x1234; iwait stays high until dwait completes plus the bubble; then icache is served.
- **Starvation guard:** STARVE_LIMIT=4, iREN held, dREN re-asserted continuously → exactly 4 dcache completions, then an icache grant, then the counter reads 0.
- **Abort:** dREN drops in DGRANT before ACCESS → ramREN=0 the same cycle, no dwait low pulse, IDLE next edge; a pending iREN is granted on the following edge.
- **ERROR retry and reset mid-grant:** ramstate=ERROR for 5 cycles then ACCESS → the wait pulse occurs only on the ACCESS cycle. Separately, nRST pulse in IGRANT → immediate reset outputs and restart from IDLE.
